// File: rtl/comparator_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_serial_if
//  Description : Handshake bundle for comparator_serial. Carries the operand
//                transfer (in_valid/in_ready, a, b, is_signed) and the result
//                transfer (out_valid/out_ready, three mutually exclusive
//                magnitude flags) plus the busy status.
//                master : the upstream/downstream environment
//                slave  : the comparator
//  Revision    : 1.0 - initial release
// ============================================================================
interface comparator_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             a_eq_b;
    logic             busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, a_gt_b, a_lt_b, a_eq_b, busy
    );
endinterface
`default_nettype wire

// File: rtl/comparator_serial.sv
`default_nettype none
// ============================================================================
//  Module      : comparator_serial
//  Description : Multi-cycle magnitude comparator. Compares two WIDTH-bit
//                operands DIGIT bits per cycle, most significant digit first,
//                unsigned or two's complement per transaction.
//                Ports:
//                  clk   - rising-edge clock
//                  rst_n - asynchronous active-low reset
//                  bus   - comparator_serial_if.slave (operand handshake,
//                          result handshake, a_gt_b/a_lt_b/a_eq_b, busy)
//                Build option COMPARATOR_SERIAL_EARLY_EXIT_EN: stop scanning
//                at the first differing digit (latency 1..NDIG); otherwise
//                all NDIG digits are always scanned (latency NDIG).
//  Revision    : 1.0 - initial release
// ============================================================================
module comparator_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    comparator_serial_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [IDXW-1:0]  c_idx_top  = IDXW'(NDIG - 1);
    localparam logic [WIDTH-1:0] c_sign_bit = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("comparator_serial: WIDTH must be >=1 and a multiple of DIGIT");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;

    // Operands are stored already sign-adjusted: flipping the top bit of both
    // maps two's complement ordering onto unsigned ordering, so the per-digit
    // compare below is always unsigned.
    logic [NDIG-1:0][DIGIT-1:0] r_a;
    logic [NDIG-1:0][DIGIT-1:0] r_b;
    logic [IDXW-1:0]            r_idx;
    logic                       r_decided;
    logic                       r_gt;
    logic                       r_flag_gt;
    logic                       r_flag_lt;
    logic                       r_flag_eq;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic             w_diff;
    logic             w_dgt;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_mask;

    assign w_a_dig  = r_a[r_idx];
    assign w_b_dig  = r_b[r_idx];
    assign w_diff   = (w_a_dig != w_b_dig);
    assign w_dgt    = (w_a_dig > w_b_dig);
    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_mask   = bus.is_signed ? c_sign_bit : '0;

`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || (!r_decided && w_diff);
`else
    assign w_last = (r_idx == '0);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_CMP;
            S_CMP:   if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.busy      = (r_state == S_CMP);
        bus.out_valid = (r_state == S_DONE);
        bus.a_gt_b    = r_flag_gt;
        bus.a_lt_b    = r_flag_lt;
        bus.a_eq_b    = r_flag_eq;
    end

    // Datapath: operand capture, digit scan, result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= c_idx_top;
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_flag_gt <= 1'b0;
            r_flag_lt <= 1'b0;
            r_flag_eq <= 1'b0;
        end else if (w_accept) begin
            r_a       <= bus.a ^ w_mask;
            r_b       <= bus.b ^ w_mask;
            r_idx     <= c_idx_top;
            r_decided <= 1'b0;
        end else if (r_state == S_CMP) begin
            // First differing digit decides; later digits never override.
            if (!r_decided && w_diff) begin
                r_decided <= 1'b1;
                r_gt      <= w_dgt;
            end
            if (r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
            if (w_last) begin
                r_flag_gt <= r_decided ? r_gt  : (w_diff &  w_dgt);
                r_flag_lt <= r_decided ? !r_gt : (w_diff & !w_dgt);
                r_flag_eq <= !r_decided && !w_diff;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_comparator_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comparator_serial
//  Description : Directed self-checking bench for comparator_serial
//                (WIDTH=16, DIGIT=4). Expected flags and latencies are
//                hand-computed per vector for both build options.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comparator_serial;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    localparam bit c_ee = 1'b1;
`else
    localparam bit c_ee = 1'b0;
`endif
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    comparator_serial_if #(.WIDTH(16)) bus ();

    comparator_serial #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] flags();
        return {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b};
    endfunction

    // Called at posedge+1 with the DUT idle. Performs one transaction;
    // with hold>0 the result is back-pressured for hold cycles.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                           input logic [2:0] exp, input int exp_lat, input int hold,
                           input string tag);
        int cyc;
        bus.a         = ta;
        bus.b         = tb_v;
        bus.is_signed = ts;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        check(32'(bus.in_ready), 32'd1, {tag, "_in_ready_idle"});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            check(32'({bus.busy, bus.in_ready}), 32'b10, {tag, "_busy_cmp"});
            @(posedge clk); #1;
            cyc++;
        end
        check(32'(cyc), 32'(exp_lat), {tag, "_latency"});
        check(32'(flags()), 32'(exp), {tag, "_flags"});
        check(32'({bus.in_ready, bus.busy}), 32'b00, {tag, "_rdy_busy_done"});
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h0001;
            bus.b        = 16'h0002;
            @(posedge clk); #1;
            check(32'({bus.out_valid, bus.in_ready, flags()}), 32'({2'b10, exp}),
                  {tag, "_backpressure"});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check(32'({bus.out_valid, bus.in_ready}), 32'b01, {tag, "_back_idle"});
        check(32'(flags()), 32'(exp), {tag, "_flags_retained"});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check(32'({bus.in_ready, bus.out_valid, bus.busy, flags()}), 32'b100_000, "reset_state");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: equal operands always scan all digits
        run_txn(16'h1234, 16'h1234, 1'b0, EQ, 4, 0, "t1_eq");
        // 2: unsigned, decided at top digit
        run_txn(16'h8000, 16'h7FFF, 1'b0, GT, c_ee ? 1 : 4, 0, "t2_ugt");
        // 3: same operands, signed then unsigned
        run_txn(16'h8000, 16'h7FFF, 1'b1, LT, c_ee ? 1 : 4, 0, "t3_slt");
        run_txn(16'h8000, 16'h7FFF, 1'b0, GT, c_ee ? 1 : 4, 0, "t3_ugt");
        // 4: negatives differing only in the last digit
        run_txn(16'hFFFF, 16'hFFFE, 1'b1, GT, 4, 0, "t4_sgt");
        run_txn(16'h0003, 16'h0005, 1'b0, LT, 4, 0, "t4_ult");
        // extra: positive vs negative signed
        run_txn(16'h1000, 16'hF000, 1'b1, GT, c_ee ? 1 : 4, 0, "tx_sgt");
        // 5: back-pressure, decided at digit 1
        run_txn(16'h00A0, 16'h0050, 1'b0, GT, c_ee ? 3 : 4, 5, "t5_bp");
        check(32'(bus.in_ready), 32'd1, "t5_pulses_ignored");

        // 6: reset during the second CMP cycle
        bus.a         = 16'h1234;
        bus.b         = 16'h1234;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check(32'(bus.busy), 32'd1, "t6_in_cmp");
        rst_n = 1'b0;
        #1;
        check(32'({bus.out_valid, bus.in_ready, bus.busy, flags()}), 32'b010_000, "t6_async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check(32'({bus.out_valid, bus.in_ready}), 32'b01, "t6_after_release");
        run_txn(16'h0005, 16'h0009, 1'b0, LT, 4, 0, "t6_ult");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
